// File: rtl/key_cmd_pkg.sv
// key_cmd_pkg: shared types and constants for the key command sequencer.
//   cmd_t    - edit command selected by the issuer
//   state_t  - issuer FSM states
//   cmd_mask - one-hot pending-bit mask {clear, enter, back, key} for a command
package key_cmd_pkg;
    typedef enum logic [2:0] {CMD_NONE, CMD_KEY, CMD_BACK, CMD_ENTER, CMD_CLEAR} cmd_t;
    typedef enum logic [2:0] {IDLE, ISSUE, GAP, CLR_BACK, CLR_TAIL} state_t;
    localparam int BUF_DEPTH = 30;
    localparam int BUF_CHAR_MAX = 69;
    function automatic logic [3:0] cmd_mask(cmd_t c);
        return {c == CMD_CLEAR, c == CMD_ENTER, c == CMD_BACK, c == CMD_KEY};
    endfunction
endpackage

// File: rtl/btn_conditioner.sv
// btn_conditioner: 2-FF sync, debounce, rising-edge request and optional hold-to-repeat.
//   clk, rst - clock, synchronous active-high reset
//   btn      - raw asynchronous button, active-high
//   req      - one-cycle request on debounced rise and on each auto-repeat
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE = 5000000,
    parameter bit REPEAT_EN = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic req
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW = $clog2(RMAX + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RR = RW'(REPEAT_RATE);
    logic [1:0] sync;
    logic level, level_q, first, rise, rep_hit;
    logic [DW-1:0] db_cnt;
    logic [RW-1:0] rep_cnt;
    assign rise = level & ~level_q;
    // rep_cnt reads k in the k-th cycle after the rise or the previous repeat
    assign rep_hit = REPEAT_EN && level && rep_cnt == (first ? RD : RR);
    assign req = rise | rep_hit;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            level <= 1'b0;
            level_q <= 1'b0;
            first <= 1'b1;
            db_cnt <= '0;
            rep_cnt <= '0;
        end else begin
            sync <= {sync[0], btn};
            level_q <= level;
            if (sync[1] == level) db_cnt <= '0;
            else if (db_cnt == DB_LAST) begin
                level <= sync[1];
                db_cnt <= '0;
            end else db_cnt <= db_cnt + 1'b1;
            if (!level) begin
                rep_cnt <= '0;
                first <= 1'b1;
            end else if (rise || rep_hit) begin
                rep_cnt <= RW'(1);
                first <= rise;
            end else if (rep_cnt != '1) rep_cnt <= rep_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/key_cmd_sequencer.sv
// key_cmd_sequencer: turns four buttons into rate-limited key/back/enter pulses with a clear-line macro.
//   clk, rst                  - clock, synchronous active-high reset
//   btn_key/back/enter/clear  - raw asynchronous buttons, active-high
//   buf_count                 - line buffer write index, read by the clear macro
//   key, back, enter          - one-cycle command pulses to the line buffer
//   busy                      - issuer not idle
//   clearing                  - clear macro in progress
module key_cmd_sequencer
    import key_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE = 5000000,
    parameter int GAP_CYCLES = 2,
    parameter int CHAR_MAX = BUF_CHAR_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_key,
    input  logic       btn_back,
    input  logic       btn_enter,
    input  logic       btn_clear,
    input  logic [4:0] buf_count,
    output logic       key,
    output logic       back,
    output logic       enter,
    output logic       busy,
    output logic       clearing
);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int TW = $clog2(CHAR_MAX + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [GW-1:0] GAP_FULL = GW'(GAP_CYCLES);
    localparam logic [TW-1:0] TAIL_LAST = TW'(CHAR_MAX - 1);
    logic [3:0] req, pend, pend_d, issue_mask;
    state_t state, state_d;
    cmd_t sel, sel_d, pick;
    logic [GW-1:0] gap_cnt, gap_cnt_d;
    logic [TW-1:0] tail_cnt, tail_cnt_d;
    logic slot;
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b1))
        u_key (.clk(clk), .rst(rst), .btn(btn_key), .req(req[0]));
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b1))
        u_back (.clk(clk), .rst(rst), .btn(btn_back), .req(req[1]));
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b0))
        u_enter (.clk(clk), .rst(rst), .btn(btn_enter), .req(req[2]));
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b0))
        u_clear (.clk(clk), .rst(rst), .btn(btn_clear), .req(req[3]));
    assign pick = pend[3] ? CMD_CLEAR : pend[2] ? CMD_ENTER : pend[1] ? CMD_BACK : pend[0] ? CMD_KEY : CMD_NONE;
    // gap_cnt doubles as the GAP timer and the macro pulse-slot timer
    assign slot = gap_cnt == '0;
    assign busy = state != IDLE;
    assign clearing = state == CLR_BACK || state == CLR_TAIL;
    // pulses are gated by rst so nothing leaves the block in a reset cycle
    assign key = !rst && state == ISSUE && sel == CMD_KEY;
    assign enter = !rst && state == ISSUE && sel == CMD_ENTER;
    assign back = !rst && ((state == ISSUE && sel == CMD_BACK) ||
                  (slot && (state == CLR_TAIL || (state == CLR_BACK && buf_count != '0))));
    assign issue_mask = state == ISSUE ? cmd_mask(sel) : 4'b0;
    // a request in the issuing cycle survives; everything is dropped around the macro
    assign pend_d = (clearing || state_d == CLR_BACK) ? 4'b0 : (pend & ~issue_mask) | req;
    always_comb begin
        state_d = state;
        sel_d = sel;
        gap_cnt_d = gap_cnt;
        tail_cnt_d = tail_cnt;
        case (state)
            ISSUE: begin
                state_d = GAP;
                gap_cnt_d = GAP_LAST;
            end
            GAP: gap_cnt_d = gap_cnt - 1'b1;
            CLR_BACK: begin
                gap_cnt_d = slot ? GAP_FULL : gap_cnt - 1'b1;
                if (slot && buf_count == '0) state_d = CLR_TAIL;
            end
            CLR_TAIL: begin
                gap_cnt_d = slot ? GAP_FULL : gap_cnt - 1'b1;
                if (slot) tail_cnt_d = tail_cnt + 1'b1;
                if (slot && tail_cnt == TAIL_LAST) begin
                    state_d = GAP;
                    gap_cnt_d = GAP_LAST;
                end
            end
            default: ;
        endcase
        // the last GAP cycle dispatches like IDLE so back-to-back commands keep GAP_CYCLES+1 spacing
        if (state == IDLE || (state == GAP && slot)) begin
            state_d = pick == CMD_CLEAR ? CLR_BACK : pick == CMD_NONE ? IDLE : ISSUE;
            sel_d = pick;
            gap_cnt_d = '0;
            tail_cnt_d = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel <= CMD_NONE;
            pend <= '0;
            gap_cnt <= '0;
            tail_cnt <= '0;
        end else begin
            state <= state_d;
            sel <= sel_d;
            pend <= pend_d;
            gap_cnt <= gap_cnt_d;
            tail_cnt <= tail_cnt_d;
        end
    end
endmodule
